// File: rtl/nms_frame_sequencer.sv
// Frame-level controller wrapped around nms_stage: frames the {dir,mag}
// input stream, clears the stage between frames, injects zero beats to push
// out the delayed final row, and forwards exactly one frame of results with
// regenerated SOF/EOL while discarding any surplus stage outputs.
module nms_frame_sequencer #(
    parameter int IMG_WIDTH   = 1920,
    parameter int IMG_HEIGHT  = 1080,
    parameter int FLUSH_BEATS = IMG_WIDTH + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tuser,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [15:0] st_tdata,
    output logic        st_tvalid,
    output logic        st_tuser,
    output logic        st_tlast,
    input  logic        st_tready,
    output logic        st_rst_n,
    input  logic [7:0]  ns_tdata,
    input  logic        ns_tvalid,
    output logic        ns_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tuser,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_sof,
    output logic        err_eol
);

    // state | meaning
    // IDLE  | waiting for start
    // CLEAR | one cycle with the stage held in reset
    // PASS  | forwarding upstream beats into the stage
    // FLUSH | injecting zero beats to push out the last row
    // DRAIN | waiting for the final frame result to leave
    // DONE  | one-cycle completion marker
    // ABORT | one cycle with the stage held in reset, then IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PASS, S_FLUSH, S_DRAIN, S_DONE, S_ABORT
    } state_t;

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int OUT_W = $clog2(TOTAL + 1);
    localparam int FL_W  = $clog2(FLUSH_BEATS + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [OUT_W-1:0] OUT_TOTAL = OUT_W'(TOTAL);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLUSH_BEATS - 1);

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [FL_W-1:0]    flush_cnt;
    logic [OUT_W-1:0]   out_cnt;
    logic [COL_W-1:0]   out_col;
    logic               start_ok, in_beat, fl_beat, out_beat, out_open;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and all stream steering
    always_comb begin
        state_nxt  = state;
        s_tready   = 1'b0;
        st_tdata   = 16'h0000;
        st_tvalid  = 1'b0;
        st_tuser   = 1'b0;
        st_tlast   = 1'b0;
        ns_tready  = 1'b0;
        m_tdata    = 8'h00;
        m_tvalid   = 1'b0;
        m_tuser    = 1'b0;
        m_tlast    = 1'b0;
        in_beat    = 1'b0;
        fl_beat    = 1'b0;
        out_beat   = 1'b0;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        start_ok   = (state == S_IDLE) && start && !abort;
        out_open   = (out_cnt != OUT_TOTAL);

        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_PASS;
            S_PASS: begin
                st_tdata  = s_tdata;
                st_tvalid = s_tvalid;
                s_tready  = st_tready;
                st_tuser  = (col == '0) && (row == '0);
                st_tlast  = (col == COL_LAST);
                in_beat   = s_tvalid && st_tready;
                if (in_beat && col == COL_LAST && row == ROW_LAST) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                st_tvalid = 1'b1;
                st_tlast  = (col == COL_LAST);
                fl_beat   = st_tready;
                if (fl_beat && flush_cnt == FL_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (!out_open) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Result path is live only while the stage holds frame data; once the
        // frame count is met, further stage outputs are accepted and dropped.
        if (state == S_PASS || state == S_FLUSH || state == S_DRAIN) begin
            if (out_open) begin
                ns_tready = m_tready;
                m_tvalid  = ns_tvalid;
                m_tdata   = ns_tdata;
                m_tuser   = (out_cnt == '0);
                m_tlast   = (out_col == COL_LAST);
            end else begin
                ns_tready = 1'b1;
            end
            out_beat = ns_tvalid && ns_tready && out_open;
        end

        if (abort && state != S_IDLE && state != S_ABORT) state_nxt = S_ABORT;
    end

    // Position counters; col doubles as the flush column since it wraps to 0 on the last input beat
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
            out_col   <= '0;
        end else begin
            if (in_beat) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (fl_beat) begin
                flush_cnt <= flush_cnt + 1'b1;
                col       <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
            if (out_beat) begin
                out_cnt <= out_cnt + 1'b1;
                out_col <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
            end
        end
    end

    // Sticky framing-check flags on the upstream stream
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_sof <= 1'b0;
            err_eol <= 1'b0;
        end else if (in_beat) begin
            if (col == '0 && row == '0 && !s_tuser) err_sof <= 1'b1;
            if (s_tlast != (col == COL_LAST))      err_eol <= 1'b1;
        end
    end

    // Registered stage reset, low for exactly the CLEAR/ABORT cycle
    always_ff @(posedge clk) begin
        st_rst_n <= !(rst || state_nxt == S_CLEAR || state_nxt == S_ABORT);
    end

endmodule
